demultiplexor_tdm: RTL and testbench

Sequential 1-to-N time-division demultiplexer. It takes a single word stream qualified by a valid strobe and distributes consecutive words round-robin across `CANALES` registered output channels, aligned to a frame-sync marker. It is the receiving end of the team's 2-to-1 / N-to-1 multiplexing path: it rebuilds parallel channels from a serialized multiplexed stream.

---
 rtl/demultiplexor_tdm.sv | 102 ++++++++++
 tb/tb_demultiplexor_tdm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/demultiplexor_tdm.sv
// Time-division demultiplexer: spreads a valid-qualified word stream round-robin
// over CANALES registered output channels, aligned to a frame-sync marker.
module demultiplexor_tdm #(
    parameter int ANCHO   = 8,
    parameter int CANALES = 4,
    localparam int SEL    = $clog2(CANALES)
) (
    input  logic                       Reloj,
    input  logic                       Reset,
    input  logic [ANCHO-1:0]           Entrada,
    input  logic                       Valido_Entrada,
    input  logic                       Sincronia,
    output logic [CANALES*ANCHO-1:0]   Salida,
    output logic [CANALES-1:0]         Valido_Salida,
    output logic [SEL-1:0]             Canal_Actual,
    output logic                       Trama_Completa,
    output logic                       Error_Sincronia,
    output logic                       Enganchado
);

    typedef enum logic {
        ESPERA = 1'b0,
        ACTIVO = 1'b1
    } estado_t;

    estado_t                   estado;
    estado_t                   estado_next;
    logic [CANALES*ANCHO-1:0]  salida_next;
    logic [CANALES-1:0]        valido_next;
    logic [SEL-1:0]            canal_next;
    logic                      trama_next;
    logic                      error_next;
    logic                      write_en;
    logic [SEL-1:0]            write_idx;

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            estado          <= ESPERA;
            Salida          <= '0;
            Valido_Salida   <= '0;
            Canal_Actual    <= '0;
            Trama_Completa  <= 1'b0;
            Error_Sincronia <= 1'b0;
        end else begin
            estado          <= estado_next;
            Salida          <= salida_next;
            Valido_Salida   <= valido_next;
            Canal_Actual    <= canal_next;
            Trama_Completa  <= trama_next;
            Error_Sincronia <= error_next;
        end
    end

    // Every output is the registered image of these next values, so no input reaches an output combinationally.
    always_comb begin
        estado_next = estado;
        salida_next = Salida;
        valido_next = '0;
        canal_next  = Canal_Actual;
        trama_next  = 1'b0;
        error_next  = 1'b0;
        write_en    = 1'b0;
        write_idx   = '0;

        case (estado)
            ESPERA: begin
                if (Valido_Entrada && Sincronia) begin
                    write_en    = 1'b1;
                    write_idx   = '0;
                    canal_next  = SEL'(1);
                    estado_next = ACTIVO;
                end
            end
            ACTIVO: begin
                if (Valido_Entrada) begin
                    write_en = 1'b1;
                    if (Sincronia && (Canal_Actual != '0)) begin
                        // Sync mid-frame: restart at channel 0 without closing the partial frame.
                        write_idx  = '0;
                        canal_next = SEL'(1);
                        error_next = 1'b1;
                    end else begin
                        write_idx  = Canal_Actual;
                        canal_next = Canal_Actual + SEL'(1);
                        trama_next = (Canal_Actual == SEL'(CANALES - 1));
                    end
                end
            end
            default: estado_next = ESPERA;
        endcase

        for (int k = 0; k < CANALES; k++) begin
            if (write_en && (write_idx == SEL'(k))) begin
                salida_next[k*ANCHO +: ANCHO] = Entrada;
                valido_next[k]                = 1'b1;
            end
        end
    end

    assign Enganchado = (estado == ACTIVO);

endmodule

// File: tb/tb_demultiplexor_tdm.sv
// Testbench for demultiplexor_tdm: directed frame scenarios followed by random
// traffic, all checked against a channel-array model of the demultiplexer.
module tb_demultiplexor_tdm;

    localparam int ANCHO   = 8;
    localparam int CANALES = 4;
    localparam int SEL     = $clog2(CANALES);

    logic                     Reloj = 1'b0;
    logic                     Reset;
    logic [ANCHO-1:0]         Entrada;
    logic                     Valido_Entrada;
    logic                     Sincronia;
    logic [CANALES*ANCHO-1:0] Salida;
    logic [CANALES-1:0]       Valido_Salida;
    logic [SEL-1:0]           Canal_Actual;
    logic                     Trama_Completa;
    logic                     Error_Sincronia;
    logic                     Enganchado;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: plain per-channel words and the next channel number.
    int exp_chan [CANALES];
    bit exp_lock;
    int exp_next;
    int exp_written;
    bit exp_trama;
    bit exp_error;

    demultiplexor_tdm #(.ANCHO(ANCHO), .CANALES(CANALES)) dut (
        .Reloj           (Reloj),
        .Reset           (Reset),
        .Entrada         (Entrada),
        .Valido_Entrada  (Valido_Entrada),
        .Sincronia       (Sincronia),
        .Salida          (Salida),
        .Valido_Salida   (Valido_Salida),
        .Canal_Actual    (Canal_Actual),
        .Trama_Completa  (Trama_Completa),
        .Error_Sincronia (Error_Sincronia),
        .Enganchado      (Enganchado)
    );

    always #5 Reloj = ~Reloj;

    task automatic expectValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input bit r, input bit v, input bit s, input int d);
        exp_written = -1;
        exp_trama   = 1'b0;
        exp_error   = 1'b0;
        if (r) begin
            foreach (exp_chan[k]) exp_chan[k] = 0;
            exp_lock = 1'b0;
            exp_next = 0;
        end else if (v) begin
            if (s) begin
                exp_error   = exp_lock && (exp_next != 0);
                exp_written = 0;
                exp_next    = 1;
                exp_lock    = 1'b1;
            end else if (exp_lock) begin
                exp_written = exp_next;
                exp_trama   = (exp_next == CANALES - 1);
                exp_next    = (exp_next + 1) % CANALES;
            end
            if (exp_written >= 0) exp_chan[exp_written] = d;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [CANALES*ANCHO-1:0] exp_salida;
        logic [CANALES-1:0]       exp_valido;
        exp_salida = '0;
        exp_valido = '0;
        for (int k = 0; k < CANALES; k++) exp_salida[k*ANCHO +: ANCHO] = exp_chan[k][ANCHO-1:0];
        if (exp_written >= 0) exp_valido[exp_written] = 1'b1;
        expectValue({tag, ".salida"},     64'(Salida),          64'(exp_salida));
        expectValue({tag, ".valido"},     64'(Valido_Salida),   64'(exp_valido));
        expectValue({tag, ".canal"},      64'(Canal_Actual),    64'(exp_next));
        expectValue({tag, ".trama"},      64'(Trama_Completa),  64'(exp_trama));
        expectValue({tag, ".error"},      64'(Error_Sincronia), 64'(exp_error));
        expectValue({tag, ".enganchado"}, 64'(Enganchado),      64'(exp_lock));
    endtask

    // Drive one cycle of inputs, advance the model with the same inputs, then check just after the edge.
    task automatic applyStimulus(input string tag, input bit r, input bit v, input bit s, input logic [ANCHO-1:0] d);
        Reset          = r;
        Valido_Entrada = v;
        Sincronia      = s;
        Entrada        = d;
        @(posedge Reloj);
        modelStep(r, v, s, int'(d));
        #1;
        checkOutput(tag);
    endtask

    initial begin
        Reset          = 1'b1;
        Valido_Entrada = 1'b0;
        Sincronia      = 1'b0;
        Entrada        = '0;
        foreach (exp_chan[k]) exp_chan[k] = 0;
        exp_lock = 1'b0;
        exp_next = 0;

        applyStimulus("reset0", 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus("reset1", 1'b1, 1'b1, 1'b1, 8'hFF);
        expectValue("reset_salida", 64'(Salida), 64'h0);

        applyStimulus("drop0", 1'b0, 1'b1, 1'b0, 8'h01);
        applyStimulus("drop1", 1'b0, 1'b1, 1'b0, 8'h02);
        applyStimulus("drop2", 1'b0, 1'b1, 1'b0, 8'h03);
        expectValue("drop_salida", 64'(Salida), 64'h0);
        expectValue("drop_lock",   64'(Enganchado), 64'h0);

        applyStimulus("f1_w11", 1'b0, 1'b1, 1'b1, 8'h11);
        expectValue("f1_valido0", 64'(Valido_Salida), 64'b0001);
        applyStimulus("f1_w22", 1'b0, 1'b1, 1'b0, 8'h22);
        expectValue("f1_valido1", 64'(Valido_Salida), 64'b0010);
        applyStimulus("f1_w33", 1'b0, 1'b1, 1'b0, 8'h33);
        expectValue("f1_valido2", 64'(Valido_Salida), 64'b0100);
        applyStimulus("f1_w44", 1'b0, 1'b1, 1'b0, 8'h44);
        expectValue("f1_valido3", 64'(Valido_Salida), 64'b1000);
        expectValue("f1_salida",  64'(Salida), 64'h44332211);
        expectValue("f1_trama",   64'(Trama_Completa), 64'h1);
        expectValue("f1_canal",   64'(Canal_Actual), 64'h0);

        applyStimulus("f2_w55", 1'b0, 1'b1, 1'b1, 8'h55);
        expectValue("f2_error_exp", 64'(Error_Sincronia), 64'h0);
        applyStimulus("f2_w66", 1'b0, 1'b1, 1'b0, 8'h66);
        applyStimulus("f2_w77", 1'b0, 1'b1, 1'b1, 8'h77);
        expectValue("resync_error", 64'(Error_Sincronia), 64'h1);
        expectValue("resync_salida", 64'(Salida), 64'h44336677);
        expectValue("resync_canal", 64'(Canal_Actual), 64'h1);
        expectValue("resync_trama", 64'(Trama_Completa), 64'h0);

        applyStimulus("gap_wA0", 1'b0, 1'b1, 1'b0, 8'hA0);
        applyStimulus("gap_idle0", 1'b0, 1'b0, 1'b0, 8'h5A);
        expectValue("gap_canal", 64'(Canal_Actual), 64'h2);
        applyStimulus("gap_idle1", 1'b0, 1'b0, 1'b0, 8'hC3);
        applyStimulus("gap_wA1", 1'b0, 1'b1, 1'b0, 8'hA1);
        expectValue("gap_salida", 64'(Salida), 64'h44A1A077);

        applyStimulus("sync_novalid", 1'b0, 1'b0, 1'b1, 8'hEE);
        expectValue("sync_novalid_canal", 64'(Canal_Actual), 64'h3);
        expectValue("sync_novalid_error", 64'(Error_Sincronia), 64'h0);

        applyStimulus("rst_w10", 1'b0, 1'b1, 1'b1, 8'h10);
        applyStimulus("rst_w20", 1'b0, 1'b1, 1'b0, 8'h20);
        applyStimulus("rst_mid", 1'b1, 1'b1, 1'b0, 8'h99);
        expectValue("rst_mid_salida", 64'(Salida), 64'h0);
        expectValue("rst_mid_lock",   64'(Enganchado), 64'h0);
        expectValue("rst_mid_canal",  64'(Canal_Actual), 64'h0);
        applyStimulus("rst_drop", 1'b0, 1'b1, 1'b0, 8'h42);
        expectValue("rst_drop_salida", 64'(Salida), 64'h0);

        for (int i = 0; i < 600; i++) begin
            applyStimulus("rand",
                          ($urandom_range(99) < 2),
                          ($urandom_range(99) < 75),
                          ($urandom_range(99) < 20),
                          ANCHO'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
